// File: rtl/multi_register_sequencer_pkg.sv
// Shared definitions for the multi-function register sequencer.
//   - op_e       : command opcodes carried on cmd_op
//   - state_e    : sequencer control states
//   - DATA_W_DEF / CNT_W_DEF : default register and repeat-count widths
//   - is_single_shot : ops that always run exactly one EXEC cycle
package multi_register_sequencer_pkg;

  localparam int DATA_W_DEF = 4;
  localparam int CNT_W_DEF  = 4;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_LOAD = 3'd1,
    OP_INC  = 3'd2,
    OP_DEC  = 3'd3,
    OP_SHL  = 3'd4,
    OP_SHR  = 3'd5,
    OP_CLR  = 3'd6,
    OP_ILL  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  // LOAD and CLR are idempotent, and an illegal op only needs one cycle to
  // be reported, so the repeat count is ignored for all three.
  function automatic logic is_single_shot(input op_e op);
    return (op == OP_LOAD) || (op == OP_CLR) || (op == OP_ILL);
  endfunction

endpackage

// File: rtl/multi_register_sequencer_decode.sv
// op_strobe_decode: turns an opcode plus an issue enable into the one-hot
// register control strobes. NOP and illegal ops decode to no strobe, so at
// most one output is high in any cycle.
//   op     : opcode being executed
//   issue  : high in a cycle where the op's strobe may fire
//   en/clr/inc/dec/shl/shr : register control strobes
module op_strobe_decode
  import multi_register_sequencer_pkg::*;
(
  input  op_e  op,
  input  logic issue,
  output logic en,
  output logic clr,
  output logic inc,
  output logic dec,
  output logic shl,
  output logic shr
);

  always_comb begin
    en  = 1'b0;
    clr = 1'b0;
    inc = 1'b0;
    dec = 1'b0;
    shl = 1'b0;
    shr = 1'b0;
    if (issue) begin
      unique case (op)
        OP_LOAD: en  = 1'b1;
        OP_CLR:  clr = 1'b1;
        OP_INC:  inc = 1'b1;
        OP_DEC:  dec = 1'b1;
        OP_SHL:  shl = 1'b1;
        OP_SHR:  shr = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/multi_register_sequencer.sv
// multi_register_sequencer: accepts one command at a time over cmd_valid /
// cmd_ready and drives the external multi-function register's control
// strobes for rep+1 cycles (one cycle for LOAD, CLR and illegal ops).
// A running command can end early through abort or stop-on-zero; every
// command ends with a single-cycle done pulse qualified by aborted/illegal.
// Ports:
//   clk, reset (async, active-low)
//   cmd_valid/cmd_ready, cmd_op, cmd_data, cmd_rep, cmd_soz : command channel
//   abort   : terminate the running command
//   reg_q   : current register value (used for stop-on-zero)
//   reg_in, reg_en, reg_clr, reg_inc, reg_dec, reg_shl, reg_shr : register controls
//   busy, done, aborted, illegal : status
module multi_register_sequencer
  import multi_register_sequencer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [CNT_W-1:0]  cmd_rep,
  input  logic              cmd_soz,
  input  logic              abort,
  input  logic [DATA_W-1:0] reg_q,
  output logic [DATA_W-1:0] reg_in,
  output logic              reg_en,
  output logic              reg_clr,
  output logic              reg_inc,
  output logic              reg_dec,
  output logic              reg_shl,
  output logic              reg_shr,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              illegal
);

  state_e              state, state_nxt;
  op_e                 op_p0;
  logic [DATA_W-1:0]   data_p0;
  logic [CNT_W-1:0]    rem_p0;
  logic                soz_p0;
  logic                aborted_p0;

  logic accept;
  logic stop;
  logic last;
  logic issue;

  assign accept = cmd_valid && cmd_ready;
  assign stop   = abort || (soz_p0 && (reg_q == '0));
  assign last   = (rem_p0 == '0);
  assign issue  = (state == EXEC) && !stop;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    if (stop || last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Command latch stage: captured at acceptance, held for the whole command.
  // rem_p0 counts down to zero and stops there, so rep = all-ones cannot wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      op_p0      <= OP_NOP;
      data_p0    <= '0;
      rem_p0     <= '0;
      soz_p0     <= 1'b0;
      aborted_p0 <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && accept) begin
        op_p0      <= op_e'(cmd_op);
        data_p0    <= cmd_data;
        rem_p0     <= is_single_shot(op_e'(cmd_op)) ? '0 : cmd_rep;
        soz_p0     <= cmd_soz;
        aborted_p0 <= 1'b0;
      end else if (state == EXEC) begin
        if (stop) begin
          aborted_p0 <= 1'b1;
        end else if (!last) begin
          rem_p0 <= rem_p0 - 1'b1;
        end
      end
    end
  end

  op_strobe_decode u_decode (
    .op    (op_p0),
    .issue (issue),
    .en    (reg_en),
    .clr   (reg_clr),
    .inc   (reg_inc),
    .dec   (reg_dec),
    .shl   (reg_shl),
    .shr   (reg_shr)
  );

  // cmd_ready is gated by reset so it reads 0 while reset is held.
  assign cmd_ready = (state == IDLE) && reset;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign aborted   = done && aborted_p0;
  assign illegal   = done && (op_p0 == OP_ILL);
  assign reg_in    = data_p0;

endmodule

// File: tb/tb_multi_register_sequencer.sv
module tb_multi_register_sequencer;

  localparam int DATA_W = 4;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [2:0]        cmd_op = '0;
  logic [DATA_W-1:0] cmd_data = '0;
  logic [CNT_W-1:0]  cmd_rep = '0;
  logic              cmd_soz = 1'b0;
  logic              abort = 1'b0;
  logic [DATA_W-1:0] reg_q;
  logic [DATA_W-1:0] reg_in;
  logic              reg_en, reg_clr, reg_inc, reg_dec, reg_shl, reg_shr;
  logic              busy, done, aborted, illegal;

  int n_checks = 0;
  int n_errors = 0;
  logic [3:0] exp_val = '0;

  always #5 clk = ~clk;

  multi_register_sequencer #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .cmd_rep(cmd_rep), .cmd_soz(cmd_soz),
    .abort(abort), .reg_q(reg_q), .reg_in(reg_in),
    .reg_en(reg_en), .reg_clr(reg_clr), .reg_inc(reg_inc), .reg_dec(reg_dec),
    .reg_shl(reg_shl), .reg_shr(reg_shr),
    .busy(busy), .done(done), .aborted(aborted), .illegal(illegal)
  );

  // The external 4-bit multi-function register driven by the sequencer.
  logic [3:0] reg_val = '0;
  always @(posedge clk) begin
    if (reg_clr)      reg_val <= '0;
    else if (reg_en)  reg_val <= reg_in;
    else if (reg_inc) reg_val <= reg_val + 4'd1;
    else if (reg_dec) reg_val <= reg_val - 4'd1;
    else if (reg_shl) reg_val <= {reg_val[2:0], 1'b0};
    else if (reg_shr) reg_val <= {1'b0, reg_val[3:1]};
  end
  assign reg_q = reg_val;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] op_mask(input int op);
    case (op)
      1: return 6'b100000;
      6: return 6'b010000;
      2: return 6'b001000;
      3: return 6'b000100;
      4: return 6'b000010;
      5: return 6'b000001;
      default: return 6'b000000;
    endcase
  endfunction

  // Transaction-level reference: how many EXEC cycles, how many strobes,
  // how it ends and what the register holds afterwards.
  function automatic void model(input int op, input int d, input int rep, input int soz,
                                input int abort_at, input logic [3:0] v0,
                                output int ncyc, output int nstb, output int ab,
                                output int ill, output logic [3:0] vf);
    int cycles;
    logic [3:0] v;
    v = v0; nstb = 0; ab = 0; ncyc = 0;
    ill = (op == 7) ? 1 : 0;
    cycles = (op == 1 || op == 6 || op == 7) ? 1 : rep + 1;
    for (int i = 0; i < cycles; i++) begin
      ncyc = i + 1;
      if (i == abort_at || (soz != 0 && v == 0)) begin
        ab = 1;
        break;
      end
      case (op)
        1: v = d[3:0];
        2: v = v + 1;
        3: v = v - 1;
        4: v = v << 1;
        5: v = v >> 1;
        6: v = 0;
        default: ;
      endcase
      if (op >= 1 && op <= 6) nstb++;
    end
    vf = v;
  endfunction

  task automatic run_cmd(input int op, input int d, input int rep, input int soz, input int abort_at);
    int ncyc, nstb, ab, ill;
    logic [3:0] vf;
    int c, got_stb, got_done;
    logic [5:0] s, m;
    logic bad_kind, bad_in, bad_flags, bad_busy;
    model(op, d, rep, soz, abort_at, exp_val, ncyc, nstb, ab, ill, vf);
    m = op_mask(op);
    @(negedge clk);
    check("ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = op[2:0];
    cmd_data  = d[3:0];
    cmd_rep   = rep[3:0];
    cmd_soz   = soz[0];
    @(negedge clk);
    cmd_valid = 1'b0;
    c = 0; got_stb = 0; got_done = 0;
    bad_kind = 0; bad_in = 0; bad_flags = 0; bad_busy = 0;
    while (!got_done && c < 40) begin
      abort = (c == abort_at);
      #1;
      s = {reg_en, reg_clr, reg_inc, reg_dec, reg_shl, reg_shr};
      if (done) begin
        got_done = 1;
        abort = 1'b0;
        check("done_aborted", aborted, ab);
        check("done_illegal", illegal, ill);
        check("done_strobes", s, 0);
        check("done_busy", busy, 1);
        check("done_ready", cmd_ready, 0);
        // Offer a command during DONE; it must not be taken.
        cmd_valid = 1'b1;
        cmd_op    = 3'd2;
        cmd_rep   = 4'd0;
        cmd_soz   = 1'b0;
      end else begin
        if (s != 0) got_stb++;
        if (s != 0 && s != m) bad_kind = 1;
        if (reg_en && reg_in != d[3:0]) bad_in = 1;
        if (aborted || illegal) bad_flags = 1;
        if (!busy || cmd_ready) bad_busy = 1;
        c++;
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    abort = 1'b0;
    check("done_seen", got_done, 1);
    check("exec_cycles", c, ncyc);
    check("strobe_count", got_stb, nstb);
    check("strobe_kind", bad_kind, 0);
    check("reg_in_data", bad_in, 0);
    check("flags_outside_done", bad_flags, 0);
    check("busy_in_exec", bad_busy, 0);
    check("no_accept_in_done", busy, 0);
    check("ready_after_done", cmd_ready, 1);
    check("reg_value", reg_val, vf);
    exp_val = vf;
  endtask

  initial begin
    int op, d, rep, soz, ab_at;
    // Reset state
    #2;
    check("rst_strobes", {reg_en, reg_clr, reg_inc, reg_dec, reg_shl, reg_shr}, 0);
    check("rst_reg_in", reg_in, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_flags", {aborted, illegal}, 0);
    check("rst_ready", cmd_ready, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1 check("ready_after_rst", cmd_ready, 1);

    run_cmd(1, 5, 0, 0, -1);      // LOAD 5
    run_cmd(2, 0, 3, 0, -1);      // INC x4 -> 9
    run_cmd(1, 3, 0, 0, -1);      // LOAD 3
    run_cmd(3, 0, 15, 1, -1);     // DEC soz -> 3 strobes, aborted
    run_cmd(1, 1, 0, 0, -1);
    run_cmd(4, 0, 7, 0, 2);       // SHL, abort in 3rd cycle

    // abort held in IDLE has no effect
    @(negedge clk);
    abort = 1'b1;
    repeat (2) begin
      @(negedge clk);
      #1;
      check("idle_abort_busy", busy, 0);
      check("idle_abort_done", done, 0);
      check("idle_abort_strobes", {reg_en, reg_clr, reg_inc, reg_dec, reg_shl, reg_shr}, 0);
    end
    abort = 1'b0;

    run_cmd(7, 0, 5, 0, -1);      // illegal
    run_cmd(6, 0, 9, 0, -1);      // CLR
    run_cmd(2, 0, 15, 0, -1);     // 16 INCs, counter must not wrap
    run_cmd(1, 0, 0, 1, -1);      // soz with reg 0: zero strobes
    run_cmd(0, 0, 4, 0, -1);      // NOP delay

    // Reset in the middle of SHR rep=10
    run_cmd(1, 12, 0, 0, -1);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd5; cmd_rep = 4'd10; cmd_soz = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("midrst_strobes", {reg_en, reg_clr, reg_inc, reg_dec, reg_shl, reg_shr}, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_ready", cmd_ready, 0);
    @(negedge clk);
    reset = 1'b1;
    #1 check("midrst_ready_release", cmd_ready, 1);
    repeat (2) begin
      @(negedge clk);
      #1 check("midrst_no_done", {done, busy}, 0);
    end
    run_cmd(1, 6, 0, 0, -1);

    // Random commands
    for (int k = 0; k < 80; k++) begin
      op    = $urandom_range(0, 7);
      d     = $urandom_range(0, 15);
      rep   = $urandom_range(0, 15);
      soz   = ($urandom_range(0, 3) == 0) ? 1 : 0;
      ab_at = ($urandom_range(0, 4) == 0) ? $urandom_range(0, rep + 1) : -1;
      run_cmd(op, d, rep, soz, ab_at);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
